// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART receiver, transmitter and prescaler
package uart_pkg;
  localparam int CLKS_PER_BIT = 5208;
  localparam int N = 13;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: reloadable bit-time down-counter, ticks at zero while enabled
module rx_bit_timer #(
  parameter int N = 13,
  parameter int RELOAD = 5207
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic         tick
);
  logic [N-1:0] count;
  assign tick = en && count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= load ? load_val : tick ? N'(RELOAD) : count - 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling mid-bit from the synchronized start edge, with framing-error detection
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int N = uart_pkg::N,
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);
  import uart_pkg::*;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int IW = $clog2(DATA_BITS + 1);
  logic s1, rx_s, tick;
  state_t state;
  logic [IW-1:0] idx;
  logic [DATA_BITS-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, rx_s} <= 2'b11;
    else {s1, rx_s} <= {rx, s1};
  rx_bit_timer #(.N(N), .RELOAD(CLKS_PER_BIT - 1)) timer (
    .clk(clk),
    .rst(rst),
    .en(state != IDLE),
    .load(state == IDLE && !rx_s),
    .load_val(N'(HALF - 1)),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      sr <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          busy <= 1'b1;
        end
        START: if (tick) begin
          idx <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy <= 1'b0;
          end else state <= DATA;
        end
        DATA: if (tick) begin
          sr <= {rx_s, sr[DATA_BITS-1:1]};
          if (idx == IW'(DATA_BITS - 1)) state <= STOP;
          else idx <= idx + 1'b1;
        end
        STOP: if (tick) begin
          if (rx_s) begin
            data <= sr;
            valid <= 1'b1;
            state <= IDLE;
            busy <= 1'b0;
          end else begin
            frame_err <= 1'b1;
            state <= BREAK;
          end
        end
        BREAK: if (rx_s) begin
          // a line held low must go high before a new start edge is accepted
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame table plus corner-case sequences for uart_rx
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx2 = 1'b1;
  logic [7:0] data, data2;
  logic valid, frame_err, busy, valid2, frame_err2, busy2;
  always #5 clk = ~clk;
  uart_rx #(.CLKS_PER_BIT(16), .N(13), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );
  uart_rx #(.CLKS_PER_BIT(17), .N(13), .DATA_BITS(8)) dut17 (
    .clk(clk), .rst(rst), .rx(rx2), .data(data2), .valid(valid2), .frame_err(frame_err2), .busy(busy2)
  );
  int checks = 0, errors = 0, cyc = 0, v_cnt = 0, f_cnt = 0, v2_cnt = 0, f2_cnt = 0, bad = 0;
  logic [7:0] hist [0:63];
  int t_hist [0:63];
  logic pv = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (valid) begin
      hist[v_cnt % 64] = data;
      t_hist[v_cnt % 64] = cyc;
      v_cnt++;
      if (busy) bad++;
    end
    if (frame_err) f_cnt++;
    if (valid && frame_err) bad++;
    if ((valid || frame_err) && pv) bad++;
    pv = valid || frame_err;
    if (valid2) v2_cnt++;
    if (frame_err2) f2_cnt++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int n);
    rx = 1'b0;
    repeat (n) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (n) @(negedge clk);
    end
    rx = stop;
    repeat (n) @(negedge clk);
  endtask
  task automatic send2(input logic [7:0] b, input int ps);
    rx2 = 1'b0;
    #(ps);
    for (int i = 0; i < 8; i++) begin
      rx2 = b[i];
      #(ps);
    end
    rx2 = 1'b1;
    #(ps);
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask
  typedef struct {
    logic [7:0] b;
    logic stop;
    int dv;
    int df;
    logic [7:0] dexp;
  } vec_t;
  vec_t tbl [7];
  initial begin
    int v0, f0, fall;
    logic seen;
    logic [7:0] d0;
    tbl[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    tbl[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    tbl[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
    tbl[5] = '{8'h5A, 1'b0, 0, 1, 8'h81};
    tbl[6] = '{8'h01, 1'b1, 1, 0, 8'h01};
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      v0 = v_cnt;
      f0 = f_cnt;
      send(tbl[i].b, tbl[i].stop, 16);
      rx = 1'b1;
      wait_idle(40);
      repeat (4) @(negedge clk);
      chk("vec_valid", v_cnt - v0, tbl[i].dv);
      chk("vec_ferr", f_cnt - f0, tbl[i].df);
      chk("vec_data", data, tbl[i].dexp);
    end
    v0 = v_cnt;
    f0 = f_cnt;
    seen = 1'b0;
    fall = 0;
    rx = 1'b0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (j == 4) rx = 1'b1;
      if (busy) seen = 1'b1;
      if (seen && !busy && fall == 0) fall = j;
    end
    chk("glitch_busy_seen", {31'd0, seen}, 1);
    chk("glitch_busy_fall", (fall >= 9 && fall <= 13) ? 1 : 0, 1);
    chk("glitch_valid", v_cnt - v0, 0);
    chk("glitch_ferr", f_cnt - f0, 0);
    v0 = v_cnt;
    f0 = f_cnt;
    d0 = data;
    send(8'h3C, 1'b0, 16);
    repeat (48) @(negedge clk);
    chk("break_busy_held", {31'd0, busy}, 1);
    chk("break_ferr", f_cnt - f0, 1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("break_busy_release", {31'd0, busy}, 0);
    repeat (200) @(negedge clk);
    chk("break_valid", v_cnt - v0, 0);
    chk("break_ferr_once", f_cnt - f0, 1);
    chk("break_data_kept", data, d0);
    v0 = v_cnt;
    send(8'h00, 1'b1, 16);
    send(8'hFF, 1'b1, 16);
    wait_idle(40);
    repeat (4) @(negedge clk);
    chk("b2b_count", v_cnt - v0, 2);
    chk("b2b_first", hist[v0 % 64], 8'h00);
    chk("b2b_second", hist[(v0 + 1) % 64], 8'hFF);
    chk("b2b_spacing", t_hist[(v0 + 1) % 64] - t_hist[v0 % 64], 160);
    v0 = v_cnt;
    f0 = f_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h81 >> i;
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_data", data, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("midrst_no_valid", v_cnt - v0, 0);
    chk("midrst_no_ferr", f_cnt - f0, 0);
    send(8'h81, 1'b1, 16);
    wait_idle(40);
    repeat (4) @(negedge clk);
    chk("after_rst_valid", v_cnt - v0, 1);
    chk("after_rst_data", data, 8'h81);
    v0 = v2_cnt;
    f0 = f2_cnt;
    send2(8'hA5, 175);
    repeat (60) @(negedge clk);
    chk("slow_valid", v2_cnt - v0, 1);
    chk("slow_data", data2, 8'hA5);
    send2(8'hC3, 165);
    repeat (60) @(negedge clk);
    chk("fast_valid", v2_cnt - v0, 2);
    chk("fast_data", data2, 8'hC3);
    chk("skew_ferr", f2_cnt - f0, 0);
    chk("skew_busy", {31'd0, busy2}, 0);
    chk("pulse_rules", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
